// File: rtl/bike_bram_sweep_ctrl.sv
// Purpose: walks a BIKE polynomial in block RAM one word per cycle (addresses 0..WORDS-1)
//          and delays a {valid, addr, last} tag so it lines up with the RAM data output.
// Latency: first read enable one cycle after start; each tag appears BRAM_LAT cycles after its read;
//          done pulses one cycle after the last tagged beat.
// Backpressure: none by default. With BIKE_SWEEP_PAUSE_EN defined, input pause stalls issue
//          in SWEEP (bubbles enter the tag line); beats already in flight still drain on schedule.
// Ports: clk, resetn (async active-low), start (sampled in IDLE only), busy, done (1-cycle pulse),
//        ren/raddr (BRAM read port), out_valid/out_addr/out_last (tags aligned with RAM data),
//        pause (only when BIKE_SWEEP_PAUSE_EN is defined).
module bike_bram_sweep_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int WORDS    = 21,
  parameter int BRAM_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
`ifdef BIKE_SWEEP_PAUSE_EN
  input  logic              pause,
`endif
  output logic              busy,
  output logic              done,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              hold;
  logic              issue;
  logic              issue_last;

  // Tag delay line; index BRAM_LAT-1 is the stage aligned with the RAM output.
  logic              vld_q [BRAM_LAT];
  logic [ADDR_W-1:0] adr_q [BRAM_LAT];
  logic              lst_q [BRAM_LAT];

`ifdef BIKE_SWEEP_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // A read is issued on every SWEEP cycle that is not stalled.
  assign issue      = (state_q == S_SWEEP) && !hold;
  assign issue_last = issue && (cnt_q == LAST_ADDR);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_SWEEP;
      S_SWEEP: if (issue_last) state_d = S_DRAIN;
      // The final tag carries last; leave once it reaches the output stage.
      S_DRAIN: if (out_last)   state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    done  = (state_q == S_DONE);
    ren   = issue;
    // raddr follows the counter for the whole SWEEP state so it holds during a pause.
    raddr = (state_q == S_SWEEP) ? cnt_q : '0;
  end

  // Address counter: wraps to 0 after the last read so the next sweep starts clean.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= issue_last ? '0 : cnt_q + ADDR_W'(1);
    end
  end

  // Tag delay line. Idle and paused cycles shift in valid=0 bubbles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BRAM_LAT; i++) begin
        vld_q[i] <= 1'b0;
        adr_q[i] <= '0;
        lst_q[i] <= 1'b0;
      end
    end else begin
      vld_q[0] <= ren;
      adr_q[0] <= raddr;
      lst_q[0] <= issue_last;
      for (int i = 1; i < BRAM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[BRAM_LAT-1];
  assign out_addr  = adr_q[BRAM_LAT-1];
  assign out_last  = lst_q[BRAM_LAT-1];

endmodule

// File: tb/tb_bike_bram_sweep_ctrl.sv
// Purpose: self-checking bench for bike_bram_sweep_ctrl; default instance (21 words, latency 2)
//          and a boundary instance (32 words, latency 1). Pause sequence runs only when
//          BIKE_SWEEP_PAUSE_EN is defined.
// Observed vector packing: {busy, done, ren, raddr[4:0], out_valid, out_addr[4:0], out_last}.
module tb_bike_bram_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, start_a, start_b, pause;
  logic       a_busy, a_done, a_ren, a_out_valid, a_out_last;
  logic [4:0] a_raddr, a_out_addr;
  logic       b_busy, b_done, b_ren, b_out_valid, b_out_last;
  logic [4:0] b_raddr, b_out_addr;
  logic [14:0] obs_a, obs_b;

  bike_bram_sweep_ctrl #(.ADDR_W(5), .WORDS(21), .BRAM_LAT(2)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a),
`ifdef BIKE_SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .busy(a_busy), .done(a_done), .ren(a_ren), .raddr(a_raddr),
    .out_valid(a_out_valid), .out_addr(a_out_addr), .out_last(a_out_last)
  );

  bike_bram_sweep_ctrl #(.ADDR_W(5), .WORDS(32), .BRAM_LAT(1)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b),
`ifdef BIKE_SWEEP_PAUSE_EN
    .pause(1'b0),
`endif
    .busy(b_busy), .done(b_done), .ren(b_ren), .raddr(b_raddr),
    .out_valid(b_out_valid), .out_addr(b_out_addr), .out_last(b_out_last)
  );

  assign obs_a = {a_busy, a_done, a_ren, a_raddr, a_out_valid, a_out_addr, a_out_last};
  assign obs_b = {b_busy, b_done, b_ren, b_raddr, b_out_valid, b_out_addr, b_out_last};

  typedef struct {
    int          cyc;
    logic        start;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[10];
  int   tests = 0;
  int   fails = 0;
  int   nseen;
  int   done_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int cyc, logic st, logic bsy, logic dn, logic rn, int ra,
                              logic ov, int oa, logic ol);
    vec_t v;
    v.cyc   = cyc;
    v.start = st;
    v.exp   = {bsy, dn, rn, 5'(ra), ov, 5'(oa), ol};
    return v;
  endfunction

  // Expected outputs k cycles after the start edge (k=0 is the idle cycle holding start).
  function automatic logic [14:0] exp_vec(int k, int w, int l);
    logic bsy, dn, rn, ov, ol;
    logic [4:0] ra, oa;
    bsy = (k >= 1) && (k <= w + l);
    dn  = (k == w + l + 1);
    rn  = (k >= 1) && (k <= w);
    ra  = rn ? 5'(k - 1) : 5'd0;
    ov  = (k >= l + 1) && (k <= l + w);
    oa  = ov ? 5'(k - l - 1) : 5'd0;
    ol  = (k == l + w);
    return {bsy, dn, rn, ra, ov, oa, ol};
  endfunction

  initial begin
    // Hand-computed points of a default sweep; cycle 10 also carries an ignored start.
    tbl[0] = mk( 1, 1'b0, 1, 0, 1,  0, 0,  0, 0);
    tbl[1] = mk( 2, 1'b0, 1, 0, 1,  1, 0,  0, 0);
    tbl[2] = mk( 3, 1'b0, 1, 0, 1,  2, 1,  0, 0);
    tbl[3] = mk(10, 1'b1, 1, 0, 1,  9, 1,  7, 0);
    tbl[4] = mk(11, 1'b0, 1, 0, 1, 10, 1,  8, 0);
    tbl[5] = mk(21, 1'b0, 1, 0, 1, 20, 1, 18, 0);
    tbl[6] = mk(22, 1'b0, 1, 0, 0,  0, 1, 19, 0);
    tbl[7] = mk(23, 1'b0, 1, 0, 0,  0, 1, 20, 1);
    tbl[8] = mk(24, 1'b0, 0, 1, 0,  0, 0,  0, 0);
    tbl[9] = mk(25, 1'b0, 0, 0, 0,  0, 0,  0, 0);

    resetn = 1'b0; start_a = 1'b0; start_b = 1'b0; pause = 1'b0;
    repeat (3) step();
    #1;
    check("reset_a", obs_a, 15'd0);
    check("reset_b", obs_b, 15'd0);

    // Release reset and request a sweep in the very first cycle.
    step();
    resetn = 1'b1;
    start_a = 1'b1;
    #1;
    check("idle_after_release", obs_a, 15'd0);
    for (int k = 1; k <= 26; k++) begin
      step();
      start_a = 1'b0;
      for (int e = 0; e < 10; e++) if (tbl[e].cyc == k) start_a = tbl[e].start;
      #1;
      for (int e = 0; e < 10; e++)
        if (tbl[e].cyc == k) check($sformatf("table_c%0d", k), obs_a, tbl[e].exp);
      check($sformatf("sweep1_c%0d", k), obs_a, exp_vec(k, 21, 2));
    end

    // Start held high: sweeps relaunch every 25 cycles with the same beats.
    step();
    start_a = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 50) start_a = 1'b0;
      #1;
      check($sformatf("b2b_c%0d", k), obs_a, exp_vec(((k - 1) % 25) + 1, 21, 2));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check("b2b_idle", obs_a, 15'd0);
    end

    // Mid-sweep asynchronous reset at cycle 8.
    step();
    start_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      start_a = 1'b0;
      #1;
      check($sformatf("pre_rst_c%0d", k), obs_a, exp_vec(k, 21, 2));
    end
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", obs_a, 15'd0);
    repeat (2) step();
    resetn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      #1;
      check("post_rst_quiet", obs_a, 15'd0);
    end
    step();
    start_a = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      start_a = 1'b0;
      #1;
      check($sformatf("post_rst_sweep_c%0d", k), obs_a, exp_vec(k, 21, 2));
    end

    // Boundary: 32 words fill the 5-bit address space, latency 1.
    step();
    start_b = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step();
      start_b = 1'b0;
      #1;
      check($sformatf("bnd_c%0d", k), obs_b, exp_vec(k, 32, 1));
      if (k == 32) check("bnd_raddr_31", b_raddr, 5'd31);
      if (k == 33) check("bnd_raddr_wrap", {b_ren, b_raddr}, 6'd0);
      if (k == 33) check("bnd_last", {b_out_last, b_out_addr}, 6'h3f);
      if (k == 34) check("bnd_done", b_done, 1'b1);
    end

`ifdef BIKE_SWEEP_PAUSE_EN
    // Pause during cycles 5..7 of a default sweep.
    nseen = 0;
    done_cyc = -1;
    step();
    start_a = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      start_a = 1'b0;
      pause = (k >= 5) && (k <= 7);
      #1;
      if (pause) begin
        check("pause_ren", a_ren, 1'b0);
        check("pause_raddr", a_raddr, 5'd4);
      end
      if (k >= 7 && k <= 9) check("pause_gap", a_out_valid, 1'b0);
      if (a_out_valid) begin
        check("pause_order", a_out_addr, 5'(nseen));
        nseen++;
      end
      if (a_done) done_cyc = k;
      if (k == 26) check("pause_busy_26", a_busy, 1'b1);
    end
    pause = 1'b0;
    check("pause_count", nseen, 21);
    check("pause_done_cycle", done_cyc, 27);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bike_bram_sweep_ctrl.md
# bike_bram_sweep_ctrl

Read-sweep controller that walks a BIKE polynomial stored in block RAM one word per cycle. It issues read enables and addresses 0..WORDS-1 and delays a valid/address/last tag by the BRAM read latency, so the tags align with the RAM data output. It sits between the BRAM port and the downstream barrel-mode word consumers that step an increasing word counter in lock-step with the valid beats.

## Interface
Parameters:
- ADDR_W, 5: width of the address bus; must satisfy 2^ADDR_W ≥ WORDS.
- WORDS, 21: number of words per sweep; legal range 2 to 2^ADDR_W.
- BRAM_LAT, 2: BRAM read latency in cycles; legal range 1 to 4.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- resetn, in, 1: reset, asynchronous, active-low.
- start, in, 1: sweep request. Sampled only in IDLE.
- busy, out, 1: high from the cycle after start is accepted until the done cycle, exclusive.
- done, out, 1: single-cycle completion pulse.
- ren, out, 1: BRAM read enable.
- raddr, out, ADDR_W: BRAM read address.
- out_valid, out, 1: the BRAM data word is valid this cycle.
- out_addr, out, ADDR_W: address of the word currently on the BRAM output.
- out_last, out, 1: the current beat is word WORDS-1.
- pause, in, 1: present only with BIKE_SWEEP_PAUSE_EN (see Configuration).

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE→SWEEP when start=1.
  - SWEEP→DRAIN after the read of address WORDS-1 is issued.
  - DRAIN→DONE when the final tagged beat leaves the delay line.
  - DONE→IDLE unconditionally after one cycle.
- Address counter:
  - Increments by 1 on each issued read.
  - Compares against WORDS-1 and returns to 0 after the last read. It never exceeds WORDS-1.
  - Arithmetic is ADDR_W bits wide with no overflow, because WORDS ≤ 2^ADDR_W.
- In SWEEP: ren=1 and raddr equals the counter. Outside SWEEP: ren=0 and raddr=0.
- Tag delay line: BRAM_LAT stages carrying {valid, addr, last}.
  - Stage 0 is loaded with {ren, raddr, raddr==WORDS-1 && ren}.
  - out_* are driven from the final stage.
- start is ignored outside IDLE, including in the DONE cycle.
- Reset, at any time including mid-sweep:
  - FSM returns to IDLE.
  - Counter and all delay stages clear.
  - busy, done, ren, raddr, out_valid, out_addr and out_last are all 0.
  - Any in-flight beats are discarded with no partial done.

## Timing
- start is high at edge E0. From the cycle after E0:
  - ren=1 for WORDS consecutive cycles, with raddr 0,1,…,WORDS-1.
  - out_valid is high during cycles BRAM_LAT+1 … BRAM_LAT+WORDS.
  - out_addr equals the raddr issued BRAM_LAT cycles earlier.
- out_last is coincident with the beat where out_addr=WORDS-1.
- done pulses in cycle WORDS+BRAM_LAT+1, one cycle after out_last.
- busy is high in cycles 1 … WORDS+BRAM_LAT and low in the done cycle.
- Minimum start-to-start spacing is WORDS+BRAM_LAT+2 cycles. A start held high continuously re-launches on the first IDLE cycle.

## Configuration
- BIKE_SWEEP_PAUSE_EN defined:
  - Adds input pause.
  - While in SWEEP with pause=1: ren=0, raddr holds its value, the counter holds, and a valid=0 bubble enters the delay line.
  - Beats already in flight still emerge on schedule.
  - The sweep resumes at the held address once pause=0.
  - pause has no effect in IDLE, DRAIN or DONE.
  - Each paused cycle extends completion by one cycle.
- BIKE_SWEEP_PAUSE_EN undefined: no pause port. Behaviour is exactly as described above.

## Test plan
- Reset check: deassert resetn with defaults (WORDS=21, BRAM_LAT=2). All outputs are 0 and FSM is IDLE. A start in the first cycle after release is accepted.
- Single sweep with defaults:
  - raddr 0..20 in cycles 1..21.
  - out_valid in cycles 3..23.
  - out_last at cycle 23 with out_addr=20.
  - done at cycle 24 only.
  - busy high in cycles 1..23.
- Start while busy: a start pulse at cycle 10 causes no change. Back-to-back starts held high give sweeps launching 25 cycles apart with identical beat sequences.
- Boundary configuration WORDS=32, ADDR_W=5, BRAM_LAT=1:
  - raddr reaches 31 and returns to 0.
  - out_last is at cycle 33.
  - done is at cycle 34.
- Mid-sweep reset: assert resetn=0 at cycle 8. All outputs are 0 immediately (asynchronous) and no done follows. A new start after release produces a full, correct sweep from address 0.
- With BIKE_SWEEP_PAUSE_EN, pause high in cycles 5..7:
  - raddr holds at 4 with ren=0.
  - out_valid has a 3-cycle gap.
  - All 21 addresses appear exactly once, in order.
  - done moves to cycle 27.
